// File: rtl/hazard_unit_pkg.sv
// Shared types for the pipeline hazard controller.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package hazard_unit_pkg;

  localparam int CNTW_DEFAULT = 16;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } hstate_t;

  // Winning stall/flush cause for the current cycle; only one is ever active.
  typedef enum logic [2:0] {
    NONE  = 3'd0,
    LDUSE = 3'd1,
    DMISS = 3'd2,
    REDIR = 3'd3,
    IMISS = 3'd4
  } cause_t;

  // True when a load into dst feeds src. r0 never creates a dependency.
  function automatic logic reg_dep(regbits_t dst, regbits_t src);
    return (dst != '0) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
// Latency: count visible one clock after inc.
// Backpressure: none; clr has priority over inc.
//
// Ports: clk, clr (sync clear), inc (count enable), cnt (current value).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller: latch enables/flushes for the 5-stage pipeline.
// Latency: control outputs combinational (same cycle); state, ihit_q, counters registered.
// Backpressure: freezes PC and latches on dmem miss, load-use and imiss; halt freezes all.
//
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   ihit, dhit                  imem / dmem completion this cycle
//   IDrs, IDrt, IDusesRt        sources of the ID instruction
//   EXrt, EXmemREN              load destination in EX
//   MMmemREN, MMmemWEN          MM stage data memory access
//   MMpcsrc                     taken branch/jump resolved in MM
//   WBhalt                      halt instruction reached WB
//   PCen..MMWBen                latch enables
//   IFIDflush..EXMMflush        bubble insert (overrides enable)
//   halted                      sticky halt indicator
//   ldstall_cnt/dstall_cnt/flush_cnt   saturating statistics
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int CNTW = CNTW_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic [4:0]      IDrs,
  input  logic [4:0]      IDrt,
  input  logic            IDusesRt,
  input  logic [4:0]      EXrt,
  input  logic            EXmemREN,
  input  logic            MMmemREN,
  input  logic            MMmemWEN,
  input  logic            MMpcsrc,
  input  logic            WBhalt,
  output logic            PCen,
  output logic            IFIDen,
  output logic            IDEXen,
  output logic            EXMMen,
  output logic            MMWBen,
  output logic            IFIDflush,
  output logic            IDEXflush,
  output logic            EXMMflush,
  output logic            halted,
  output logic [CNTW-1:0] ldstall_cnt,
  output logic [CNTW-1:0] dstall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  hstate_t state, state_nxt;
  cause_t  cause;
  logic    ihit_q;
  logic    dmiss, lduse, ifready;

  assign dmiss   = (MMmemREN | MMmemWEN) & ~dhit;
  assign lduse   = EXmemREN & (reg_dep(EXrt, IDrs) | (IDusesRt & reg_dep(EXrt, IDrt)));
  // A fetch that landed while PC was frozen still counts as ready.
  assign ifready = ihit | ihit_q;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. DWAIT simply tracks an outstanding dmem miss;
  // the dhit cycle drops back to RUN and is handled by the normal rules.
  always_comb begin
    state_nxt = state;
    case (state)
      HALT:    state_nxt = HALT;
      default: begin
        if (WBhalt) begin
          state_nxt = HALT;
        end else if (dmiss) begin
          state_nxt = DWAIT;
        end else begin
          state_nxt = RUN;
        end
      end
    endcase
  end

  // Pick the single highest-priority cause for this cycle.
  always_comb begin
    cause = NONE;
    if (RST || (state == HALT)) begin
      cause = NONE;
    end else if (dmiss) begin
      cause = DMISS;
    end else if (MMpcsrc) begin
      cause = REDIR;
    end else if (lduse) begin
      cause = LDUSE;
    end else if (!ifready) begin
      cause = IMISS;
    end
  end

  // Output logic
  always_comb begin
    PCen      = 1'b1;
    IFIDen    = 1'b1;
    IDEXen    = 1'b1;
    EXMMen    = 1'b1;
    MMWBen    = 1'b1;
    IFIDflush = 1'b0;
    IDEXflush = 1'b0;
    EXMMflush = 1'b0;
    halted    = 1'b0;
    if (RST) begin
      // Hold everything and keep bubbles in the latches while in reset.
      PCen      = 1'b0;
      IFIDen    = 1'b0;
      IDEXen    = 1'b0;
      EXMMen    = 1'b0;
      MMWBen    = 1'b0;
      IFIDflush = 1'b1;
      IDEXflush = 1'b1;
      EXMMflush = 1'b1;
    end else if (state == HALT) begin
      PCen   = 1'b0;
      IFIDen = 1'b0;
      IDEXen = 1'b0;
      EXMMen = 1'b0;
      MMWBen = 1'b0;
      halted = 1'b1;
    end else begin
      case (cause)
        DMISS: begin
          PCen   = 1'b0;
          IFIDen = 1'b0;
          IDEXen = 1'b0;
          EXMMen = 1'b0;
          MMWBen = 1'b0;
        end
        REDIR: begin
          // Three younger instructions are on the wrong path.
          IFIDflush = 1'b1;
          IDEXflush = 1'b1;
          EXMMflush = 1'b1;
        end
        LDUSE: begin
          PCen      = 1'b0;
          IFIDen    = 1'b0;
          IDEXflush = 1'b1;
        end
        IMISS: begin
          PCen      = 1'b0;
          IFIDflush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sticky fetch-complete: remembers an ihit that arrived while PC was held.
  // A redirect discards it because that fetch was on the wrong path.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ihit_q <= 1'b0;
    end else if (PCen || MMpcsrc) begin
      ihit_q <= 1'b0;
    end else if (ihit) begin
      ihit_q <= 1'b1;
    end
  end

  sat_counter #(.W(CNTW)) u_ldstall_cnt (
    .clk (CLK),
    .clr (RST),
    .inc (cause == LDUSE),
    .cnt (ldstall_cnt)
  );

  sat_counter #(.W(CNTW)) u_dstall_cnt (
    .clk (CLK),
    .clr (RST),
    .inc (cause == DMISS),
    .cnt (dstall_cnt)
  );

  sat_counter #(.W(CNTW)) u_flush_cnt (
    .clk (CLK),
    .clr (RST),
    .inc (cause == REDIR),
    .cnt (flush_cnt)
  );

endmodule
